// File: rtl/flex_buffer_pkg.sv
// Shared width helpers and handshake typedef for the flex FIFO buffer.
package flex_buffer_pkg;

    typedef struct packed {
        logic valid;
        logic ready;
    } hs_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/flex_wrap_counter.sv
// Pointer counter that wraps MAX -> 0 by explicit compare, so MAX+1 need not be a power of 2.
module flex_wrap_counter #(
    parameter int W   = 2,
    parameter int MAX = 3
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clear,
    input  logic         incr,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    always_ff @(posedge clk) begin
        if (!n_rst)
            value <= '0;
        else if (clear)
            value <= '0;
        else if (incr)
            value <= (value == MAX_V) ? '0 : value + 1'b1;
    end

endmodule

// File: rtl/flex_fifo_buffer.sv
// DEPTH-entry show-ahead FIFO with valid/ready on both sides, occupancy count,
// almost-full flag, synchronous flush and sticky overflow/underflow flags.
module flex_fifo_buffer
    import flex_buffer_pkg::*;
#(
    parameter int NUM_BITS  = 32,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = 3
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_BITS-1:0]         input_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_BITS-1:0]         output_data,
    output logic [cnt_w(DEPTH)-1:0]     count,
    output logic                        almost_full,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [NUM_BITS-1:0] mem [DEPTH];
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic                full, empty, push, pop;
    hs_t                 in_hs, out_hs;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Readiness comes from state alone; a pop cannot free a slot for a same-cycle push.
    assign in_ready  = !full;
    assign out_valid = !empty;

    assign in_hs  = '{valid: in_valid,  ready: in_ready};
    assign out_hs = '{valid: out_valid, ready: out_ready};

    assign push = in_hs.valid  & in_hs.ready  & !flush;
    assign pop  = out_hs.valid & out_hs.ready & !flush;

    flex_wrap_counter #(.W(PW), .MAX(DEPTH-1)) u_wr_ptr (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (flush),
        .incr  (push),
        .value (wr_ptr)
    );

    flex_wrap_counter #(.W(PW), .MAX(DEPTH-1)) u_rd_ptr (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (flush),
        .incr  (pop),
        .value (rd_ptr)
    );

    // Storage is deliberately left out of reset; count/pointers define validity.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= input_data;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            if (in_valid && full)
                overflow <= 1'b1;
            if (out_ready && empty)
                underflow <= 1'b1;
        end
    end

    assign almost_full = (count >= CW'(AF_THRESH));
    assign output_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_flex_fifo_buffer.sv
// Directed self-checking bench for flex_fifo_buffer (NUM_BITS=32, DEPTH=4, AF_THRESH=3).
module tb_flex_fifo_buffer;

    logic        clk = 1'b0;
    logic        n_rst, flush, in_valid, out_ready;
    logic [31:0] input_data;
    logic        in_ready, out_valid, almost_full, overflow, underflow;
    logic [31:0] output_data;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    flex_fifo_buffer #(.NUM_BITS(32), .DEPTH(4), .AF_THRESH(3)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .input_data  (input_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .output_data (output_data),
        .count       (count),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d);
        in_valid   = 1'b1;
        input_data = d;
        step();
        in_valid   = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; input_data = '0;
        step();
        step();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_checks++; if (output_data !== 32'h0) begin n_fail++; $display("FAIL reset_output_data got=%h exp=0", output_data); end
        n_checks++; if ({almost_full, overflow, underflow} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {almost_full, overflow, underflow}); end
        n_rst = 1'b1;
        step();
    endtask

    task automatic test_fill_drain();
        logic [31:0] a [4] = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
        for (int i = 0; i < 4; i++) begin
            push_word(a[i]);
            n_checks++; if (count !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
            n_checks++; if (almost_full !== (i + 1 >= 3)) begin n_fail++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, almost_full, (i + 1 >= 3)); end
            n_checks++; if (in_ready !== (i + 1 < 4)) begin n_fail++; $display("FAIL fill_in_ready[%0d] got=%b exp=%b", i, in_ready, (i + 1 < 4)); end
            n_checks++; if (output_data !== 32'hA1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL fill_head[%0d] got=%h/%b exp=a1/1", i, output_data, out_valid); end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (output_data !== a[i]) begin n_fail++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, output_data, a[i]); end
            step();
            n_checks++; if (count !== 3'(3 - i)) begin n_fail++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, count, 3 - i); end
        end
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || output_data !== 32'h0) begin n_fail++; $display("FAIL drain_empty got=%b/%h exp=0/0", out_valid, output_data); end
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL drain_underflow got=%b exp=0", underflow); end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 11; k++) begin
            in_valid   = (k < 10);
            input_data = 32'h10 + 32'(k);
            out_ready  = (k > 0);
            step();
            if (k < 10) begin
                n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL wrap_count[%0d] got=%0d exp=1", k, count); end
                n_checks++; if (output_data !== 32'h10 + 32'(k)) begin n_fail++; $display("FAIL wrap_data[%0d] got=%h exp=%h", k, output_data, 32'h10 + 32'(k)); end
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_checks++; if (count !== 3'd0 || underflow !== 1'b0) begin n_fail++; $display("FAIL wrap_end got=%0d/%b exp=0/0", count, underflow); end
    endtask

    task automatic test_full_simul();
        logic [31:0] exp_q [4] = '{32'hB1, 32'hB2, 32'hB3, 32'hBC};
        for (int i = 0; i < 4; i++) push_word(32'hB0 + 32'(i));
        in_valid = 1'b1; input_data = 32'hBB; out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready_comb got=%b exp=0", in_ready); end
        step();
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL full_simul_count got=%0d exp=3", count); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_simul_overflow got=%b exp=1", overflow); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_simul_in_ready got=%b exp=1", in_ready); end
        out_ready = 1'b0; input_data = 32'hBC;
        step();
        in_valid = 1'b0;
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_repush_count got=%0d exp=4", count); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (output_data !== exp_q[i]) begin n_fail++; $display("FAIL full_drain[%0d] got=%h exp=%h", i, output_data, exp_q[i]); end
            step();
        end
        out_ready = 1'b0;
        n_checks++; if (overflow !== 1'b1 || count !== 3'd0) begin n_fail++; $display("FAIL full_sticky got=%b/%0d exp=1/0", overflow, count); end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL flush_pre_underflow got=%b exp=1", underflow); end
        for (int i = 0; i < 3; i++) push_word(32'hC0 + 32'(i));
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
        flush = 1'b1; in_valid = 1'b1; input_data = 32'hDD;
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_state got=%0d/%b exp=0/0", count, out_valid); end
        n_checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL flush_flags got=%b%b exp=00", overflow, underflow); end
        n_checks++; if (output_data !== 32'h0) begin n_fail++; $display("FAIL flush_data got=%h exp=0", output_data); end
        push_word(32'hE0);
        n_checks++; if (output_data !== 32'hE0 || count !== 3'd1) begin n_fail++; $display("FAIL flush_after got=%h/%0d exp=e0/1", output_data, count); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_empty_reset();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++; if (underflow !== 1'b1 || count !== 3'd0) begin n_fail++; $display("FAIL empty_pop got=%b/%0d exp=1/0", underflow, count); end
        push_word(32'hF0);
        push_word(32'hF1);
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL midrst_pre_count got=%0d exp=2", count); end
        n_rst = 1'b0;
        step();
        n_checks++; if (count !== 3'd0 || underflow !== 1'b0) begin n_fail++; $display("FAIL midrst_state got=%0d/%b exp=0/0", count, underflow); end
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_hs got=%b/%b exp=0/1", out_valid, in_ready); end
        n_rst = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_simul();
        test_flush();
        test_empty_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
